eth_rx_fcs_checker: RTL and testbench

Receive-side counterpart of the MAC's CRC-32 generator. It sits between the RX byte assembler (preamble/SFD already stripped) and the RX client interface. It runs the IEEE 802.3 CRC-32 over every received byte including the 4-byte FCS, strips the FCS from the forwarded stream through a 4-byte delay line, checks frame length, and issues one status record per frame. There is no backpressure: the PHY side cannot stall, so the block accepts every beat.

---
 rtl/eth_rx_fcs_checker_if.sv | 24 ++
 rtl/eth_rx_fcs_checker.sv | 76 +++++++
 tb/tb_eth_rx_fcs_checker.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/eth_rx_fcs_checker_if.sv
// eth_rx_fcs_checker_if: receive byte stream in, FCS-stripped stream and per-frame status out
interface eth_rx_fcs_checker_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_last;
    logic        rx_err;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        stat_valid;
    logic        stat_good;
    logic        stat_crc_err;
    logic        stat_len_err;
    logic        stat_phy_err;
    logic [15:0] stat_len;
    modport master (
        output rx_data, rx_valid, rx_last, rx_err,
        input  m_data, m_valid, m_last, stat_valid, stat_good, stat_crc_err, stat_len_err, stat_phy_err, stat_len
    );
    modport slave (
        input  rx_data, rx_valid, rx_last, rx_err,
        output m_data, m_valid, m_last, stat_valid, stat_good, stat_crc_err, stat_len_err, stat_phy_err, stat_len
    );
endinterface

// File: rtl/eth_rx_fcs_checker.sv
// eth_rx_fcs_checker: CRC-32 residue check, FCS strip via 4-byte delay line, length check and per-frame status
module eth_rx_fcs_checker #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input logic clk,
    input logic reset,
    eth_rx_fcs_checker_if.slave bus
);
    localparam logic [31:0] POLY    = 32'h04C11DB7;
    localparam logic [31:0] RESIDUE = 32'hC704DD7B;
    localparam logic [15:0] MIN_L   = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L   = 16'(MAX_LEN);
    typedef enum logic {FILL, PASS} state_t;
    state_t      state;
    logic [31:0] crc, crc_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [31:0] dl;
    logic        phy, phy_nxt, crc_bad, len_bad;
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? POLY : 32'h0);
        return r;
    endfunction
    always_comb begin
        crc_nxt = crc_byte(crc, bus.rx_data);
        cnt_nxt = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
        phy_nxt = phy | bus.rx_err;
        crc_bad = crc_nxt != RESIDUE;
        len_bad = (cnt_nxt < MIN_L) || (cnt_nxt > MAX_L);
    end
    // dl[31:24] is the byte accepted four beats ago
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= FILL;
            crc              <= '1;
            cnt              <= '0;
            dl               <= '0;
            phy              <= 1'b0;
            bus.m_data       <= '0;
            bus.m_valid      <= 1'b0;
            bus.m_last       <= 1'b0;
            bus.stat_valid   <= 1'b0;
            bus.stat_good    <= 1'b0;
            bus.stat_crc_err <= 1'b0;
            bus.stat_len_err <= 1'b0;
            bus.stat_phy_err <= 1'b0;
            bus.stat_len     <= '0;
        end else begin
            bus.m_valid    <= bus.rx_valid && state == PASS;
            bus.m_last     <= bus.rx_valid && state == PASS && bus.rx_last;
            bus.stat_valid <= bus.rx_valid && bus.rx_last;
            if (bus.rx_valid) begin
                bus.m_data <= dl[31:24];
                dl         <= {dl[23:0], bus.rx_data};
                if (bus.rx_last) begin
                    state            <= FILL;
                    crc              <= '1;
                    cnt              <= '0;
                    phy              <= 1'b0;
                    bus.stat_good    <= !(crc_bad || len_bad || phy_nxt);
                    bus.stat_crc_err <= crc_bad;
                    bus.stat_len_err <= len_bad;
                    bus.stat_phy_err <= phy_nxt;
                    bus.stat_len     <= cnt_nxt;
                end else begin
                    crc <= crc_nxt;
                    cnt <= cnt_nxt;
                    phy <= phy_nxt;
                    if (state == FILL && cnt == 16'd3) state <= PASS;
                end
            end
        end
    end
endmodule

// File: tb/tb_eth_rx_fcs_checker.sv
// tb_eth_rx_fcs_checker: two DUTs (MIN_LEN=1 and default) fed the same frames, scoreboard-checked
module tb_eth_rx_fcs_checker;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [7:0]  frm[$];
    logic [8:0]  ed[2][$];
    logic [19:0] es[2][$];

    always #5 clk = ~clk;

    eth_rx_fcs_checker_if ia ();
    eth_rx_fcs_checker_if ib ();
    assign ib.rx_data  = ia.rx_data;
    assign ib.rx_valid = ia.rx_valid;
    assign ib.rx_last  = ia.rx_last;
    assign ib.rx_err   = ia.rx_err;

    eth_rx_fcs_checker #(.MIN_LEN(1)) u_a (.clk(clk), .reset(reset), .bus(ia));
    eth_rx_fcs_checker u_b (.clk(clk), .reset(reset), .bus(ib));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // reflected (0xEDB88320) CRC-32, the standard software formulation
    function automatic logic [31:0] crc_refl(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic mk(input int n, input int seed);
        logic [31:0] c;
        frm.delete();
        c = '1;
        for (int i = 0; i < n; i++) begin
            frm.push_back(8'(seed + i * 7));
            c = crc_refl(c, frm[i]);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) frm.push_back(8'(c >> (8 * i)));
    endtask

    task automatic idle();
        @(negedge clk);
        ia.rx_valid = 1'b0;
        ia.rx_last  = 1'b0;
        ia.rx_err   = 1'b0;
    endtask

    task automatic send(input int err_idx, input int gap, input bit full);
        int          n;
        logic [31:0] c;
        logic        ce, phy, le_a, le_b;
        n = frm.size();
        for (int i = 0; i < n - 4; i++) begin
            ed[0].push_back({full && i == n - 5, frm[i]});
            ed[1].push_back({full && i == n - 5, frm[i]});
        end
        if (full) begin
            c = '1;
            for (int i = 0; i < n; i++) c = crc_refl(c, frm[i]);
            ce   = c != 32'hDEBB20E3;
            phy  = err_idx >= 0 && err_idx < n;
            le_a = n < 1 || n > 1518;
            le_b = n < 64 || n > 1518;
            es[0].push_back({!(ce || le_a || phy), ce, le_a, phy, 16'(n)});
            es[1].push_back({!(ce || le_b || phy), ce, le_b, phy, 16'(n)});
        end
        for (int i = 0; i < n; i++) begin
            if (gap > 0 && i % gap == gap - 1) idle();
            @(negedge clk);
            ia.rx_data  = frm[i];
            ia.rx_valid = 1'b1;
            ia.rx_last  = full && i == n - 1;
            ia.rx_err   = i == err_idx;
        end
    endtask

    // monitor: compares every presented output against the head of its queue
    always @(negedge clk) begin
        logic       mv, sv;
        logic [8:0] od;
        logic [19:0] os;
        for (int w = 0; w < 2; w++) begin
            mv = (w == 1) ? ib.m_valid : ia.m_valid;
            sv = (w == 1) ? ib.stat_valid : ia.stat_valid;
            od = (w == 1) ? {ib.m_last, ib.m_data} : {ia.m_last, ia.m_data};
            os = (w == 1) ? {ib.stat_good, ib.stat_crc_err, ib.stat_len_err, ib.stat_phy_err, ib.stat_len}
                          : {ia.stat_good, ia.stat_crc_err, ia.stat_len_err, ia.stat_phy_err, ia.stat_len};
            if (mv) begin
                if (ed[w].size() == 0) chk($sformatf("dut%0d unexpected_data", w), {23'h0, od}, 32'hFFFFFFFF);
                else chk($sformatf("dut%0d data{last,byte}", w), {23'h0, od}, {23'h0, ed[w].pop_front()});
            end
            if (sv) begin
                if (es[w].size() == 0) chk($sformatf("dut%0d unexpected_stat", w), {12'h0, os}, 32'hFFFFFFFF);
                else chk($sformatf("dut%0d stat{good,crc,len,phy,len16}", w), {12'h0, os}, {12'h0, es[w].pop_front()});
            end
        end
    end

    initial begin
        ia.rx_data  = '0;
        ia.rx_valid = 1'b0;
        ia.rx_last  = 1'b0;
        ia.rx_err   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset a outputs", {ia.m_valid, ia.m_last, ia.stat_valid, ia.stat_good, ia.stat_crc_err,
                                ia.stat_len_err, ia.stat_phy_err, ia.m_data, ia.stat_len}, 32'h0);
        chk("reset b outputs", {ib.m_valid, ib.m_last, ib.stat_valid, ib.stat_good, ib.stat_crc_err,
                                ib.stat_len_err, ib.stat_phy_err, ib.m_data, ib.stat_len}, 32'h0);
        reset = 1'b0;
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
        send(-1, 0, 1'b1);
        frm[4] = 8'h34;
        send(-1, 0, 1'b1);
        mk(60, 3);   send(-1, 0, 1'b1);
        mk(59, 11);  send(-1, 0, 1'b1);
        mk(1515, 5); send(-1, 0, 1'b1);
        mk(1514, 9); send(-1, 0, 1'b1);
        mk(0, 0);    send(-1, 0, 1'b1);
        mk(1, 77);   send(-1, 0, 1'b1);
        frm = '{8'h10, 8'h20, 8'h30};
        send(-1, 0, 1'b1);
        idle();
        mk(60, 21);  send(10, 3, 1'b1);
        mk(60, 40);  send(-1, 0, 1'b1);
        idle();
        mk(16, 55);  send(-1, 0, 1'b0);
        @(negedge clk);
        reset       = 1'b1;
        ia.rx_valid = 1'b0;
        ia.rx_last  = 1'b0;
        ia.rx_err   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mk(60, 99);  send(-1, 0, 1'b1);
        idle();
        for (int k = 0; k < 50 && (ed[0].size() + ed[1].size() + es[0].size() + es[1].size()) != 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("dut0 data drained", ed[0].size(), 0);
        chk("dut1 data drained", ed[1].size(), 0);
        chk("dut0 stat drained", es[0].size(), 0);
        chk("dut1 stat drained", es[1].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
